// File: rtl/oddr_odelay_tx.sv
// Output DDR register plus a tap-stepping controller for an external output delay line.
// Define ODDR_ODELAY_TX_READBACK_EN to add delay-line count readback and the tap_mismatch flag.
module oddr_odelay_tx #(
  parameter int WIDTH         = 1,
  parameter int TAP_BITS      = 9,
  parameter int MAX_TAP       = 511,
  parameter int INIT_TAP      = 0,
  parameter int SETTLE_CYCLES = 8
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [WIDTH-1:0]    d1,
  input  logic [WIDTH-1:0]    d2,
  output logic [WIDTH-1:0]    q,
  input  logic [TAP_BITS-1:0] tap_target,
  input  logic                tap_valid,
  output logic                tap_ready,
  output logic [TAP_BITS-1:0] tap_current,
  output logic                busy,
  output logic                done,
  output logic                dly_rst,
  output logic                dly_en_vtc,
  output logic                dly_ce,
  output logic                dly_inc
`ifdef ODDR_ODELAY_TX_READBACK_EN
  ,
  input  logic [TAP_BITS-1:0] dly_cnt_value_in,
  output logic                tap_mismatch
`endif
);

  localparam logic [TAP_BITS-1:0] MAX_TAP_V   = TAP_BITS'(MAX_TAP);
  localparam logic [TAP_BITS:0]   MAX_TAP_EXT = (TAP_BITS + 1)'(MAX_TAP);
  localparam logic [TAP_BITS-1:0] INIT_TAP_V  = TAP_BITS'(INIT_TAP);
  localparam logic [7:0]          SETTLE_LAST = 8'(SETTLE_CYCLES - 1);

  typedef enum logic [2:0] {IDLE, VTC_OFF, STEP, GAP, VTC_ON} state_t;

  state_t                state, next_state;
  logic [7:0]            settle_cnt;
  logic [TAP_BITS-1:0]   target_q;
  logic [TAP_BITS-1:0]   clamped;
  logic                  accept;
  logic                  last_settle;
  logic [WIDTH-1:0]      d1_r, d2_r, d2_n;

  // DDR path: d2 is moved to a falling-edge register so the clock-select mux only
  // switches between stable values.
  always_ff @(posedge clk) begin
    if (rst) begin
      d1_r <= '0;
      d2_r <= '0;
    end else begin
      d1_r <= d1;
      d2_r <= d2;
    end
  end

  always_ff @(negedge clk) begin
    d2_n <= d2_r;
  end

  assign q = clk ? d1_r : d2_n;

  assign accept      = tap_valid & tap_ready;
  assign clamped     = ({1'b0, tap_target} > MAX_TAP_EXT) ? MAX_TAP_V : tap_target;
  assign last_settle = (settle_cnt == SETTLE_LAST);

  assign tap_ready  = (state == IDLE) & ~rst;
  assign busy       = (state != IDLE);
  assign dly_rst    = rst;
  assign dly_ce     = (state == STEP);
  assign dly_en_vtc = !((state == VTC_OFF) || (state == STEP) || (state == GAP));

  always_comb begin
    next_state = state;
    case (state)
      IDLE:    if (accept && (clamped != tap_current)) next_state = VTC_OFF;
      VTC_OFF: if (last_settle) next_state = STEP;
      STEP:    next_state = GAP;
      GAP:     next_state = (tap_current == target_q) ? VTC_ON : STEP;
      VTC_ON:  if (last_settle) next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  // Direction is fixed on entry to STEP so dly_inc is stable around each CE pulse.
  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      settle_cnt  <= '0;
      tap_current <= INIT_TAP_V;
      target_q    <= INIT_TAP_V;
      dly_inc     <= 1'b0;
      done        <= 1'b0;
    end else begin
      state <= next_state;
      done  <= 1'b0;
      if (next_state != state)
        settle_cnt <= '0;
      else if ((state == VTC_OFF) || (state == VTC_ON))
        settle_cnt <= settle_cnt + 8'd1;
      if (accept) begin
        target_q <= clamped;
        if (clamped == tap_current) done <= 1'b1;
      end
      if ((state == VTC_ON) && last_settle) done <= 1'b1;
      if ((next_state == STEP) && (state != STEP)) dly_inc <= (target_q > tap_current);
      if (state == STEP)
        tap_current <= dly_inc ? tap_current + 1'b1 : tap_current - 1'b1;
    end
  end

`ifdef ODDR_ODELAY_TX_READBACK_EN
  always_ff @(posedge clk) begin
    if (rst || accept)
      tap_mismatch <= 1'b0;
    else if ((state == VTC_ON) && last_settle)
      tap_mismatch <= (dly_cnt_value_in != tap_current);
  end
`endif

endmodule

// File: tb/tb_oddr_odelay_tx.sv
// Bench for oddr_odelay_tx: DDR vector table plus request sequences checked against a timeline model.
// Readback checks are compiled in when ODDR_ODELAY_TX_READBACK_EN is defined.
module tb_oddr_odelay_tx;
  localparam int WIDTH    = 2;
  localparam int TAP_BITS = 10;
  localparam int MAX_TAP  = 511;
  localparam int INIT_TAP = 0;
  localparam int SETTLE   = 8;

  logic                clk = 1'b0;
  logic                rst;
  logic [WIDTH-1:0]    d1, d2, q;
  logic [TAP_BITS-1:0] tap_target, tap_current;
  logic                tap_valid, tap_ready, busy, done;
  logic                dly_rst, dly_en_vtc, dly_ce, dly_inc;
`ifdef ODDR_ODELAY_TX_READBACK_EN
  logic [TAP_BITS-1:0] dly_cnt_value_in;
  logic                tap_mismatch;
`endif

  int checks = 0;
  int errors = 0;
  int model_tap;

  typedef struct {
    logic [WIDTH-1:0] d1;
    logic [WIDTH-1:0] d2;
    logic [WIDTH-1:0] exp_hi;
    logic [WIDTH-1:0] exp_lo;
  } ddr_vec_t;

  ddr_vec_t vecs[16];

  oddr_odelay_tx #(
    .WIDTH(WIDTH), .TAP_BITS(TAP_BITS), .MAX_TAP(MAX_TAP),
    .INIT_TAP(INIT_TAP), .SETTLE_CYCLES(SETTLE)
  ) dut (
    .clk(clk), .rst(rst), .d1(d1), .d2(d2), .q(q),
    .tap_target(tap_target), .tap_valid(tap_valid), .tap_ready(tap_ready),
    .tap_current(tap_current), .busy(busy), .done(done), .dly_rst(dly_rst),
    .dly_en_vtc(dly_en_vtc), .dly_ce(dly_ce), .dly_inc(dly_inc)
`ifdef ODDR_ODELAY_TX_READBACK_EN
    , .dly_cnt_value_in(dly_cnt_value_in), .tap_mismatch(tap_mismatch)
`endif
  );

  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("[TB] FAIL watchdog: simulation did not complete, got timeout, required finish");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0d, expected %0d (t=%0t)", name, actual, expected, $time);
    end
  endtask

  task automatic applyStimulus(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b);
    d1 = a;
    d2 = b;
  endtask

  // Expected controller outputs follow from the request timeline: SETTLE cycles with
  // VTC off, n step/gap pairs, SETTLE cycles with VTC on, then done.
  task automatic runRequest(input int raw, input bit noise);
    int tgt, n, last, steps, e_tap;
    bit up, e_en, e_ce, e_busy, e_done;
    tgt  = (raw > MAX_TAP) ? MAX_TAP : raw;
    up   = (tgt > model_tap);
    n    = up ? tgt - model_tap : model_tap - tgt;
    last = (n == 0) ? 1 : 2 * SETTLE + 1 + 2 * n;
    tap_target = TAP_BITS'(raw);
    tap_valid  = 1'b1;
    for (int o = 1; o <= last; o++) begin
      @(posedge clk); #1;
      tap_valid = (noise && o < last) ? 1'b1 : 1'b0;
      if (noise) tap_target = TAP_BITS'($urandom_range(0, 1023));
      if (n == 0) begin
        e_en = 1'b1; e_ce = 1'b0; e_busy = 1'b0; e_done = 1'b1; e_tap = model_tap;
      end else begin
        e_en   = !(o <= SETTLE + 2 * n);
        e_ce   = (o >= SETTLE + 1) && (o <= SETTLE - 1 + 2 * n) && (((o - SETTLE - 1) % 2) == 0);
        steps  = (o <= SETTLE) ? 0 : (o - SETTLE) / 2;
        if (steps > n) steps = n;
        e_tap  = up ? model_tap + steps : model_tap - steps;
        e_busy = (o <= 2 * SETTLE + 2 * n);
        e_done = (o == last);
        if ((o >= SETTLE + 1) && (o <= SETTLE + 2 * n))
          checkOutput($sformatf("inc@A+%0d", o), 32'(dly_inc), 32'(up));
      end
      checkOutput($sformatf("en_vtc@A+%0d", o), 32'(dly_en_vtc), 32'(e_en));
      checkOutput($sformatf("ce@A+%0d", o), 32'(dly_ce), 32'(e_ce));
      checkOutput($sformatf("tap@A+%0d", o), 32'(tap_current), 32'(e_tap));
      checkOutput($sformatf("busy@A+%0d", o), 32'(busy), 32'(e_busy));
      checkOutput($sformatf("ready@A+%0d", o), 32'(tap_ready), 32'(!e_busy));
      checkOutput($sformatf("done@A+%0d", o), 32'(done), 32'(e_done));
    end
    model_tap = tgt;
  endtask

  task automatic resetMidOp();
    int tgt;
    tgt = (model_tap >= 4) ? model_tap - 4 : model_tap + 4;
    tap_target = TAP_BITS'(tgt);
    tap_valid  = 1'b1;
    for (int o = 1; o <= 2 * SETTLE - 4; o++) begin
      @(posedge clk); #1;
      tap_valid = 1'b0;
    end
    checkOutput("midop_gap_ce", 32'(dly_ce), 32'(0));
    checkOutput("midop_gap_tap", 32'(tap_current),
                32'((tgt > model_tap) ? model_tap + 2 : model_tap - 2));
    rst = 1'b1;
    @(posedge clk); #1;
    checkOutput("rst_tap", 32'(tap_current), 32'(INIT_TAP));
    checkOutput("rst_en_vtc", 32'(dly_en_vtc), 32'(1));
    checkOutput("rst_ce", 32'(dly_ce), 32'(0));
    checkOutput("rst_busy", 32'(busy), 32'(0));
    checkOutput("rst_done", 32'(done), 32'(0));
    checkOutput("rst_ready", 32'(tap_ready), 32'(0));
    checkOutput("rst_dly_rst", 32'(dly_rst), 32'(1));
    rst = 1'b0;
    #1;
    checkOutput("post_rst_ready", 32'(tap_ready), 32'(1));
    model_tap = INIT_TAP;
    for (int i = 0; i < 2 * SETTLE + 10; i++) begin
      @(posedge clk); #1;
      checkOutput($sformatf("post_rst_done[%0d]", i), 32'(done), 32'(0));
      checkOutput($sformatf("post_rst_ce[%0d]", i), 32'(dly_ce), 32'(0));
    end
  endtask

  initial begin
    int r;
    rst = 1'b1; tap_valid = 1'b0; tap_target = '0;
    applyStimulus('1, '1);
`ifdef ODDR_ODELAY_TX_READBACK_EN
    dly_cnt_value_in = '0;
`endif
    model_tap = INIT_TAP;

    for (int i = 0; i < 16; i++) begin
      if (i < 6) begin
        vecs[i].d1 = (i % 2 == 0) ? '1 : '0;
        vecs[i].d2 = (i % 2 == 0) ? '0 : '1;
      end else begin
        vecs[i].d1 = WIDTH'($urandom);
        vecs[i].d2 = WIDTH'($urandom);
      end
      vecs[i].exp_hi = vecs[i].d1;
      vecs[i].exp_lo = vecs[i].d2;
    end

    repeat (3) @(posedge clk);
    #1;
    checkOutput("rst_q_hi", 32'(q), 32'(0));
    checkOutput("rst_tap_init", 32'(tap_current), 32'(INIT_TAP));
    checkOutput("rst_en_vtc_init", 32'(dly_en_vtc), 32'(1));
    checkOutput("rst_ready_init", 32'(tap_ready), 32'(0));
    checkOutput("rst_busy_init", 32'(busy), 32'(0));
    checkOutput("rst_ce_init", 32'(dly_ce), 32'(0));
    checkOutput("rst_inc_init", 32'(dly_inc), 32'(0));
    checkOutput("rst_done_init", 32'(done), 32'(0));
    checkOutput("rst_dly_rst_init", 32'(dly_rst), 32'(1));
    @(negedge clk); #1;
    checkOutput("rst_q_lo", 32'(q), 32'(0));
    @(posedge clk); #1;
    rst = 1'b0;
    #1;
    checkOutput("ready_after_rst", 32'(tap_ready), 32'(1));
    checkOutput("dly_rst_after_rst", 32'(dly_rst), 32'(0));

    for (int i = 0; i < 16; i++) begin
      applyStimulus(vecs[i].d1, vecs[i].d2);
      @(posedge clk); #2;
      checkOutput($sformatf("q_hi[%0d]", i), 32'(q), 32'(vecs[i].exp_hi));
      @(negedge clk); #2;
      checkOutput($sformatf("q_lo[%0d]", i), 32'(q), 32'(vecs[i].exp_lo));
    end

    @(posedge clk); #1;
    runRequest(3, 1'b0);
    runRequest(5, 1'b0);
    runRequest(2, 1'b0);
    runRequest(2, 1'b0);
    runRequest(4, 1'b1);
    runRequest(600, 1'b0);
    runRequest(1000, 1'b0);
    runRequest(480, 1'b1);
    for (int k = 0; k < 6; k++) begin
      r = model_tap + int'($urandom_range(0, 40)) - 20;
      if (r < 0) r = 0;
      if (k == 3) r = int'($urandom_range(512, 1023));
      runRequest(r, k[0]);
    end
    resetMidOp();

`ifdef ODDR_ODELAY_TX_READBACK_EN
    dly_cnt_value_in = TAP_BITS'(2);
    runRequest(3, 1'b0);
    checkOutput("mismatch_set", 32'(tap_mismatch), 32'(1));
    dly_cnt_value_in = TAP_BITS'(3);
    runRequest(3, 1'b0);
    checkOutput("mismatch_cleared", 32'(tap_mismatch), 32'(0));
    runRequest(1, 1'b0);
    checkOutput("mismatch_sticky_clear", 32'(tap_mismatch), 32'(1));
    dly_cnt_value_in = TAP_BITS'(4);
    runRequest(4, 1'b0);
    checkOutput("mismatch_match", 32'(tap_mismatch), 32'(0));
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
